// File: rtl/pcie_descrambler_128b.sv
// Per-lane 128b/130b receive descrambler: data blocks XORed with LFSR keystream, control blocks bypassed.
// Latency: 1 cycle in_valid -> out_valid, full rate with no bubbles.
// Backpressure: none; every strobed block is accepted and produced one cycle later.
module pcie_descrambler_128b #(
    parameter int          DW   = 128,
    parameter logic [22:0] SEED = 23'h1DBFBC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_is_ctl,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_is_ctl,
    output logic          out_locked,
    output logic          out_err
);

    localparam int          NSYM      = DW / 8;
    // x^21 + x^16 + x^8 + x^5 + x^2 + 1; the x^23 term is the bit shifted out.
    localparam logic [22:0] POLY_TAPS = 23'h210125;
    localparam logic [7:0]  SKP_SYM   = 8'hAA;
    localparam logic [7:0]  SKP_END   = 8'hE1;

    logic [22:0]   lfsr;
    logic [22:0]   lfsr_nxt;
    logic [22:0]   lfsr_adv;
    logic [22:0]   lfsr_walk;
    logic [DW-1:0] keystream;
    logic          is_eieos;
    logic          is_skp;
    logic [7:0]    sym0;

    // Keystream bit i is the MSB before step i, so bit 8k+b lines up with symbol k bit b.
    always_comb begin
        lfsr_walk = lfsr;
        keystream = '0;
        for (int i = 0; i < DW; i++) begin
            keystream[i] = lfsr_walk[22];
            lfsr_walk    = {lfsr_walk[21:0], 1'b0} ^ (lfsr_walk[22] ? POLY_TAPS : 23'h0);
        end
        lfsr_adv = lfsr_walk;
    end

    // EIEOS: alternating 00/FF symbols across the whole block.
    always_comb begin
        is_eieos = in_is_ctl;
        for (int k = 0; k < NSYM; k++) begin
            if (in_data[8*k +: 8] != ((k % 2 == 1) ? 8'hFF : 8'h00)) begin
                is_eieos = 1'b0;
            end
        end
    end

    assign sym0   = in_data[7:0];
    assign is_skp = in_is_ctl && !is_eieos && ((sym0 == SKP_SYM) || (sym0 == SKP_END));

    // EIEOS reload wins; SKP freezes; every other block (data or control) advances one block.
    always_comb begin
        lfsr_nxt = lfsr;
        if (in_valid) begin
            if (is_eieos) begin
                lfsr_nxt = SEED;
            end else if (!is_skp) begin
                lfsr_nxt = lfsr_adv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= SEED;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_is_ctl <= 1'b0;
            out_locked <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            lfsr      <= lfsr_nxt;
            out_valid <= in_valid;
            out_err   <= 1'b0;
            if (in_valid) begin
                out_data   <= in_is_ctl ? in_data : (in_data ^ keystream);
                out_is_ctl <= in_is_ctl;
                out_err    <= !in_is_ctl && !out_locked;
                out_locked <= out_locked | is_eieos;
            end
        end
    end

endmodule
